// File: rtl/mux_n_reg_arb_if.sv
// Handshake bundle between N producers, the registered mux/arbiter and one consumer.
// The master side is the producer/consumer environment; the slave side is the mux.
interface mux_n_reg_arb_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_n_reg_arb.sv
// Registered N:1 mux with per-channel valid/ready and a one-entry output register.
// Source is either the explicit select (MODE=0) or a round-robin search over valid inputs (MODE=1).
module mux_n_reg_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int MODE     = 0
) (
    input logic            clk,
    input logic            rst_n,
    mux_n_reg_arb_if.slave bus
);
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;

    logic                load_en;
    logic                grant_vld;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    search_idx;
    logic                xfer;
    logic [CHANNELS-1:0] in_ready_w;

    // The register can take a word when empty or when it is drained this same cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin : grant_search
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_vld  = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        if (MODE == 0) begin
            if (int'(bus.sel) < CHANNELS) begin
                grant_vld = 1'b1;
                grant_idx = bus.sel;
            end
        end else begin
            // Ascending scan from ptr with wrap; ptr is kept below CHANNELS so the wrap is one subtract.
            for (int k = 0; k < CHANNELS; k++) begin
                int idx;
                idx = int'(ptr_q) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                search_idx = SEL_W'(idx);
                if (!grant_vld && bus.in_valid[search_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = search_idx;
                end
            end
        end
    end

    always_comb begin : ready_gen
        in_ready_w = '0;
        if (rst_n && grant_vld) in_ready_w[grant_idx] = load_en;
    end

    assign bus.in_ready = in_ready_w;
    assign xfer         = grant_vld && bus.in_valid[grant_idx] && load_en;

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = bus.in_data[grant_idx*WIDTH +: WIDTH];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (MODE != 0) begin
                ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_n_reg_arb.sv
// Directed bench for the registered mux: one instance per source mode, scoreboard
// queues filled by the stimulus and drained by per-instance output monitors.
module tb_mux_n_reg_arb;
    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] chan;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];

    mux_n_reg_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus0 ();
    mux_n_reg_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus1 ();

    mux_n_reg_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .MODE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    mux_n_reg_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .MODE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] c);
        exp_t e;
        e.data = d;
        e.chan = c;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] c);
        exp_t e;
        e.data = d;
        e.chan = c;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            exp_t e;
            check("m0_pending", 64'(q0.size() > 0), 64'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("m0_data", 64'(bus0.out_data), 64'(e.data));
                check("m0_chan", 64'(bus0.out_chan), 64'(e.chan));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            exp_t e;
            check("m1_pending", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("m1_data", 64'(bus1.out_data), 64'(e.data));
                check("m1_chan", 64'(bus1.out_chan), 64'(e.chan));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Round-robin expected channel order with all four inputs valid from ptr=0.
    logic [SEL_W-1:0] rr_order [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_n          = 1'b0;
        bus0.in_data   = '0;
        bus0.in_valid  = '0;
        bus0.sel       = '0;
        bus0.out_ready = 1'b0;
        bus1.in_data   = '0;
        bus1.in_valid  = '0;
        bus1.sel       = '0;
        bus1.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst0_in_ready",  64'(bus0.in_ready),  64'h0);
        check("rst0_out_valid", 64'(bus0.out_valid), 64'h0);
        check("rst0_out_data",  64'(bus0.out_data),  64'h0);
        check("rst0_out_chan",  64'(bus0.out_chan),  64'h0);
        check("rst1_in_ready",  64'(bus1.in_ready),  64'h0);
        check("rst1_out_valid", 64'(bus1.out_valid), 64'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("rel1_in_ready_idle", 64'(bus1.in_ready), 64'h0);
        check("rel0_in_ready_sel0", 64'(bus0.in_ready), 64'h1);

        // MODE=0: explicit select of channel 2
        next_cycle();
        bus0.sel       = 2'd2;
        bus0.in_data   = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        bus0.in_valid  = 4'b0100;
        bus0.out_ready = 1'b1;
        #1;
        check("m0_sel2_in_ready", 64'(bus0.in_ready), 64'h4);
        push0(32'hDEAD_BEEF, 2'd2);
        next_cycle();
        bus0.in_valid = 4'b0000;
        #1;
        check("m0_sel2_out_valid", 64'(bus0.out_valid), 64'h1);
        check("m0_sel2_out_data",  64'(bus0.out_data),  64'hDEAD_BEEF);
        check("m0_sel2_out_chan",  64'(bus0.out_chan),  64'h2);

        // MODE=0 stall: fill with ch0 then hold with out_ready low
        next_cycle();
        bus0.sel       = 2'd0;
        bus0.in_data   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_AAAA};
        bus0.in_valid  = 4'b0001;
        bus0.out_ready = 1'b0;
        #1;
        check("m0_fill_in_ready", 64'(bus0.in_ready), 64'h1);
        push0(32'h0000_AAAA, 2'd0);
        next_cycle();
        bus0.in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_BBBB};
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus0.sel = 2'd3;
            #1;
            check("m0_stall_in_ready",  64'(bus0.in_ready),  64'h0);
            check("m0_stall_out_data",  64'(bus0.out_data),  64'h0000_AAAA);
            check("m0_stall_out_valid", 64'(bus0.out_valid), 64'h1);
            next_cycle();
        end
        // Drain and load in the same cycle
        bus0.sel       = 2'd1;
        bus0.in_data   = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_BBBB};
        bus0.in_valid  = 4'b0010;
        bus0.out_ready = 1'b1;
        #1;
        check("m0_drain_in_ready", 64'(bus0.in_ready), 64'h2);
        push0(32'h1234_5678, 2'd1);
        next_cycle();
        bus0.in_valid = 4'b0000;
        #1;
        check("m0_nobubble_valid", 64'(bus0.out_valid), 64'h1);
        check("m0_nobubble_data",  64'(bus0.out_data),  64'h1234_5678);
        next_cycle();
        #1;
        check("m0_empty_valid", 64'(bus0.out_valid), 64'h0);
        check("m0_empty_data",  64'(bus0.out_data),  64'h1234_5678);
        check("m0_empty_chan",  64'(bus0.out_chan),  64'h1);

        // MODE=1: all channels valid, wrap of the round-robin pointer
        next_cycle();
        bus1.in_data   = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        bus1.in_valid  = 4'b1111;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [SEL_W-1:0] c;
            logic [3:0]       r;
            c = rr_order[k];
            r = 4'b0001 << c;
            #1;
            check("m1_rr_in_ready", 64'(bus1.in_ready), 64'(r));
            push1(32'hC0DE_0000 | 32'(c), c);
            next_cycle();
        end
        bus1.in_valid = 4'b0000;
        #1;
        check("m1_idle_in_ready", 64'(bus1.in_ready), 64'h0);
        next_cycle();

        // MODE=1: only ch3 and ch1 valid with ptr=2
        bus1.in_data  = {32'h5555_0003, 32'h0, 32'h5555_0001, 32'h0};
        bus1.in_valid = 4'b1010;
        #1;
        check("m1_sparse_first", 64'(bus1.in_ready), 64'h8);
        push1(32'h5555_0003, 2'd3);
        next_cycle();
        #1;
        check("m1_sparse_second", 64'(bus1.in_ready), 64'h2);
        push1(32'h5555_0001, 2'd1);
        next_cycle();
        bus1.in_valid = 4'b0000;
        next_cycle();

        // Reset while a word is stalled: ch0 granted (ptr 2 -> 3 -> 0), never delivered
        bus1.in_data   = {32'h0, 32'h0, 32'h0, 32'h7777_0000};
        bus1.in_valid  = 4'b0001;
        bus1.out_ready = 1'b0;
        #1;
        check("m1_load_in_ready", 64'(bus1.in_ready), 64'h1);
        next_cycle();
        bus1.in_valid = 4'b0000;
        #1;
        check("m1_stall_valid", 64'(bus1.out_valid), 64'h1);
        check("m1_stall_data",  64'(bus1.out_data),  64'h7777_0000);
        #1;
        rst_n = 1'b0;
        #1;
        check("m1_async_valid", 64'(bus1.out_valid), 64'h0);
        check("m1_async_data",  64'(bus1.out_data),  64'h0);
        check("m1_async_chan",  64'(bus1.out_chan),  64'h0);
        next_cycle();
        bus1.in_data   = {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000};
        bus1.in_valid  = 4'b1111;
        bus1.out_ready = 1'b1;
        #1;
        check("m1_inrst_in_ready", 64'(bus1.in_ready), 64'h0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("m1_postrst_ptr0", 64'(bus1.in_ready), 64'h1);
        push1(32'h9999_0000, 2'd0);
        next_cycle();
        bus1.in_valid = 4'b0000;
        next_cycle();
        next_cycle();
        next_cycle();

        check("q0_empty", 64'(q0.size()), 64'd0);
        check("q1_empty", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
